// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
package mem_arb_pkg;

   localparam int LAT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } state_t;

   localparam int PORT_CPU = 0;
   localparam int PORT_LDR = 1;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational 2-way winner picker, one-hot output
// MEM_ARB_ROUND_ROBIN_EN selects round-robin on ties; otherwise port 0 has fixed priority.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] pick
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   always_comb begin
      pick = req;
      // On a tie, the port that was not served last wins
      if (req == 2'b11) begin
         pick = last ? 2'b01 : 2'b10;
      end
   end
`else
   logic unused_last;
   assign unused_last = last;

   always_comb begin
      pick = '0;
      if (req[PORT_CPU]) begin
         pick[PORT_CPU] = 1'b1;
      end else if (req[PORT_LDR]) begin
         pick[PORT_LDR] = 1'b1;
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port req/ack arbiter in front of the shared single-port memory
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        gnt,
   output logic              busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_t            state, state_nxt;
   logic [1:0]        gnt_nxt;
   logic [1:0]        pick;
   logic [LAT_W-1:0]  cnt, cnt_nxt;
   logic              last, last_nxt;
   logic              wr_q, wr_nxt;
   logic [DATA_W-1:0] rdata_nxt;
   logic              sel_ldr;

   arb_pick u_pick (
      .req  ({req1, req0}),
      .last (last),
      .pick (pick)
   );

   assign sel_ldr = gnt[PORT_LDR];
   assign busy    = (state != ST_IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         gnt   <= '0;
         cnt   <= '0;
         last  <= 1'b1;
         wr_q  <= 1'b0;
         rdata <= '0;
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
         cnt   <= cnt_nxt;
         last  <= last_nxt;
         wr_q  <= wr_nxt;
         rdata <= rdata_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      cnt_nxt   = cnt;
      last_nxt  = last;
      wr_nxt    = wr_q;
      rdata_nxt = rdata;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      ack0      = 1'b0;
      ack1      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req0 || req1) begin
               gnt_nxt   = pick;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // The winner's signals are sampled here only; later changes are ignored
            mem_en    = 1'b1;
            mem_we    = sel_ldr ? we1    : we0;
            mem_addr  = sel_ldr ? addr1  : addr0;
            mem_wdata = sel_ldr ? wdata1 : wdata0;
            wr_nxt    = mem_we;
            cnt_nxt   = LAT_W'(MEM_LAT - 1);
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt == '0) begin
               if (!wr_q) begin
                  rdata_nxt = mem_rdata;
               end
               state_nxt = ST_ACK;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_ACK: begin
            ack0      = gnt[PORT_CPU];
            ack1      = gnt[PORT_LDR];
            last_nxt  = gnt[PORT_LDR];
            gnt_nxt   = '0;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter at MEM_LAT 1, 2, 3 and 7
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [9:0]  addr0 = '0, addr1 = '0;
   logic [31:0] wdata0 = '0, wdata1 = '0, mem_rdata = '0;

   logic [3:0]  ack0_v, ack1_v, busy_v, mem_en_v, mem_we_v;
   logic [1:0]  gnt_v [4];
   logic [9:0]  mem_addr_v [4];
   logic [31:0] mem_wdata_v [4];
   logic [31:0] rdata_v [4];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Instance g runs with MEM_LAT = 1, 2, 3, 7; all share the same stimulus
   for (genvar g = 0; g < 4; g++) begin : g_dut
      mem_arbiter #(
         .ADDR_W  (10),
         .DATA_W  (32),
         .MEM_LAT ((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 7)
      ) u_dut (
         .clk       (clk),
         .reset     (reset),
         .req0      (req0),
         .req1      (req1),
         .we0       (we0),
         .we1       (we1),
         .addr0     (addr0),
         .addr1     (addr1),
         .wdata0    (wdata0),
         .wdata1    (wdata1),
         .ack0      (ack0_v[g]),
         .ack1      (ack1_v[g]),
         .rdata     (rdata_v[g]),
         .gnt       (gnt_v[g]),
         .busy      (busy_v[g]),
         .mem_en    (mem_en_v[g]),
         .mem_we    (mem_we_v[g]),
         .mem_addr  (mem_addr_v[g]),
         .mem_wdata (mem_wdata_v[g]),
         .mem_rdata (mem_rdata)
      );
   end

   typedef struct {
      logic        rst;
      logic        req0, we0, req1, we1;
      logic [9:0]  addr0, addr1;
      logic [31:0] wdata1, mrd;
      logic [1:0]  gnt;
      logic        busy, en, we;
      logic [9:0]  maddr;
      logic [31:0] mwd, rd;
      logic        ack0, ack1;
   } vec_t;

   vec_t vec [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   int first2, first3, first0, exp_port;
   logic exp_a0, exp_a1;

   initial begin
      // Single read on port 0 (rows 0-4), single write on port 1 (rows 5-9), MEM_LAT=1
      vec[0] = '{1'b1, 1'b1,1'b0,1'b0,1'b0, 10'h004,10'h000, 32'h0,32'hDEADBEEF, 2'b00,1'b0,1'b0,1'b0, 10'h000,32'h0,32'h0, 1'b0,1'b0};
      vec[1] = '{1'b0, 1'b1,1'b0,1'b0,1'b0, 10'h004,10'h000, 32'h0,32'hDEADBEEF, 2'b01,1'b1,1'b1,1'b0, 10'h004,32'h0,32'h0, 1'b0,1'b0};
      vec[2] = '{1'b0, 1'b1,1'b0,1'b0,1'b0, 10'h004,10'h000, 32'h0,32'hDEADBEEF, 2'b01,1'b1,1'b0,1'b0, 10'h000,32'h0,32'h0, 1'b0,1'b0};
      vec[3] = '{1'b0, 1'b1,1'b0,1'b0,1'b0, 10'h004,10'h000, 32'h0,32'hDEADBEEF, 2'b01,1'b1,1'b0,1'b0, 10'h000,32'h0,32'hDEADBEEF, 1'b1,1'b0};
      vec[4] = '{1'b0, 1'b0,1'b0,1'b0,1'b0, 10'h004,10'h000, 32'h0,32'hDEADBEEF, 2'b00,1'b0,1'b0,1'b0, 10'h000,32'h0,32'hDEADBEEF, 1'b0,1'b0};
      vec[5] = '{1'b1, 1'b0,1'b0,1'b1,1'b1, 10'h000,10'h3FF, 32'h12345678,32'hFFFFFFFF, 2'b00,1'b0,1'b0,1'b0, 10'h000,32'h0,32'h0, 1'b0,1'b0};
      vec[6] = '{1'b0, 1'b0,1'b0,1'b1,1'b1, 10'h000,10'h3FF, 32'h12345678,32'hFFFFFFFF, 2'b10,1'b1,1'b1,1'b1, 10'h3FF,32'h12345678,32'h0, 1'b0,1'b0};
      vec[7] = '{1'b0, 1'b0,1'b0,1'b1,1'b1, 10'h000,10'h3FF, 32'h12345678,32'hFFFFFFFF, 2'b10,1'b1,1'b0,1'b0, 10'h000,32'h0,32'h0, 1'b0,1'b0};
      vec[8] = '{1'b0, 1'b0,1'b0,1'b1,1'b1, 10'h000,10'h3FF, 32'h12345678,32'hFFFFFFFF, 2'b10,1'b1,1'b0,1'b0, 10'h000,32'h0,32'h0, 1'b0,1'b1};
      vec[9] = '{1'b0, 1'b0,1'b0,1'b0,1'b1, 10'h000,10'h3FF, 32'h12345678,32'hFFFFFFFF, 2'b00,1'b0,1'b0,1'b0, 10'h000,32'h0,32'h0, 1'b0,1'b0};

      for (int i = 0; i < 10; i++) begin
         if (vec[i].rst) do_reset();
         req0 = vec[i].req0; we0 = vec[i].we0; req1 = vec[i].req1; we1 = vec[i].we1;
         addr0 = vec[i].addr0; addr1 = vec[i].addr1; wdata1 = vec[i].wdata1; mem_rdata = vec[i].mrd;
         @(negedge clk);
         chk($sformatf("v%0d gnt", i),       32'(gnt_v[0]),       32'(vec[i].gnt));
         chk($sformatf("v%0d busy", i),      32'(busy_v[0]),      32'(vec[i].busy));
         chk($sformatf("v%0d mem_en", i),    32'(mem_en_v[0]),    32'(vec[i].en));
         chk($sformatf("v%0d mem_we", i),    32'(mem_we_v[0]),    32'(vec[i].we));
         chk($sformatf("v%0d mem_addr", i),  32'(mem_addr_v[0]),  32'(vec[i].maddr));
         chk($sformatf("v%0d mem_wdata", i), mem_wdata_v[0],      vec[i].mwd);
         chk($sformatf("v%0d rdata", i),     rdata_v[0],          vec[i].rd);
         chk($sformatf("v%0d ack0", i),      32'(ack0_v[0]),      32'(vec[i].ack0));
         chk($sformatf("v%0d ack1", i),      32'(ack1_v[0]),      32'(vec[i].ack1));
         next_cycle();
      end

      // Tie with both requests held, MEM_LAT=2: acks every 5 cycles starting at cycle 4
      do_reset();
      req0 = 1'b1; req1 = 1'b1; mem_rdata = 32'h0BAD_F00D;
      for (int c = 0; c <= 20; c++) begin
         exp_a0 = 1'b0; exp_a1 = 1'b0;
         if (c >= 4 && ((c - 4) % 5) == 0) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_port = ((c - 4) / 5) % 2;
`else
            exp_port = 0;
`endif
            if (exp_port == 0) exp_a0 = 1'b1; else exp_a1 = 1'b1;
         end
         @(negedge clk);
         chk($sformatf("tie c%0d ack0", c), 32'(ack0_v[1]), 32'(exp_a0));
         chk($sformatf("tie c%0d ack1", c), 32'(ack1_v[1]), 32'(exp_a1));
         next_cycle();
      end

      // Latency sweep: MEM_LAT=3 acks at cycle 5, MEM_LAT=7 at cycle 9
      do_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 10'h111; mem_rdata = 32'hCAFE0003;
      first2 = -1; first3 = -1;
      for (int c = 0; c <= 12; c++) begin
         @(negedge clk);
         if (first2 < 0 && ack0_v[2]) first2 = c;
         if (first3 < 0 && ack0_v[3]) first3 = c;
         if (c >= 1 && c <= 5) chk($sformatf("lat3 busy c%0d", c), 32'(busy_v[2]), 32'd1);
         if (c >= 1 && c <= 9) chk($sformatf("lat7 busy c%0d", c), 32'(busy_v[3]), 32'd1);
         next_cycle();
      end
      chk("lat3 ack cycle", 32'(first2), 32'd5);
      chk("lat7 ack cycle", 32'(first3), 32'd9);
      chk("lat7 rdata", rdata_v[3], 32'hCAFE0003);

      // Reset asserted in the WAIT cycle (cycle 2), released in cycle 3
      do_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 10'h022; mem_rdata = 32'h5555AAAA;
      next_cycle();
      next_cycle();
      chk("rst pre busy", 32'(busy_v[0]), 32'd1);
      reset = 1'b0;
      #1;
      chk("rst gnt",    32'(gnt_v[0]),    32'd0);
      chk("rst busy",   32'(busy_v),      32'd0);
      chk("rst mem_en", 32'(mem_en_v[0]), 32'd0);
      chk("rst ack0",   32'(ack0_v[0]),   32'd0);
      chk("rst rdata",  rdata_v[0],       32'd0);
      next_cycle();
      reset = 1'b1;
      first0 = -1; first3 = -1;
      for (int c = 3; c <= 14; c++) begin
         @(negedge clk);
         if (first0 < 0 && ack0_v[0]) first0 = c;
         if (first3 < 0 && ack0_v[3]) first3 = c;
         next_cycle();
      end
      chk("rst lat1 ack cycle", 32'(first0), 32'd6);
      chk("rst lat7 ack cycle", 32'(first3), 32'd12);

      // req0 dropped in the WAIT cycle, MEM_LAT=2: access still completes at cycle 4
      do_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 10'h055; mem_rdata = 32'hA5A50001;
      next_cycle();
      next_cycle();
      req0 = 1'b0;
      addr0 = 10'h3AA;
      for (int c = 2; c <= 7; c++) begin
         @(negedge clk);
         chk($sformatf("drop c%0d ack0", c), 32'(ack0_v[1]), (c == 4) ? 32'd1 : 32'd0);
         if (c >= 5) chk($sformatf("drop c%0d busy", c), 32'(busy_v[1]), 32'd0);
         next_cycle();
      end
      chk("drop rdata", rdata_v[1], 32'hA5A50001);
      chk("drop gnt",   32'(gnt_v[1]), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
